demultiplexer_1_2_4bit_buf: RTL
===============================

Name: demultiplexer_1_2_4bit_buf

Overview:
- Buffered 1-to-2 demultiplexer: the inverse of the 2:1 mux.
- Accepts a WIDTH-bit word on one valid/ready input and routes it by select line a into one of two independent output FIFOs (channel 0 when a=0, channel 1 when a=1).
- Each channel drains through its own valid/ready port. Used to steer bus data toward one of two consumers (e.g. register vs output latch) without stalling the other.

Parameters:
- WIDTH, 4, data word width.
- DEPTH, 2, entries per channel FIFO; legal values 2 or 4 (pointer width 1 or 2 bits).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- a  input  1  route select; 0 = channel 0, 1 = channel 1; sampled only with a transfer.
- i  input  WIDTH  input data word.
- i_valid  input  1  producer has a word on i.
- i_ready  output  1  selected channel can accept.
- o_0  output  WIDTH  channel 0 head word.
- o_0_valid  output  1  channel 0 non-empty.
- o_0_ready  input  1  channel 0 consumer takes head.
- o_1  output  WIDTH  channel 1 head word.
- o_1_valid  output  1  channel 1 non-empty.
- o_1_ready  input  1  channel 1 consumer takes head.
- cnt_0  output  4  words delivered on channel 0, mod 16.
- cnt_1  output  4  words delivered on channel 1, mod 16.

Behaviour:
- Reset (rst=1 at an edge): both FIFOs emptied (pointers and occupancy = 0); o_0_valid = o_1_valid = 0; cnt_0 = cnt_1 = 0.
- Reset mid-operation discards all buffered words. Reset has priority over every push and pop in the same cycle.
- o_k = 0 whenever channel k is empty; otherwise o_k = head entry.
- Output data is registered storage, not combinational from i.
- i_ready = NOT full[a]. It is combinational from a and occupancy only, and never depends on i_valid or on o_k_ready.
- Push:
  - Occurs when i_valid & i_ready at the edge.
  - i is written at the write pointer of channel a; that pointer advances modulo DEPTH and occupancy is incremented.
  - The unselected channel is untouched.
- Pop:
  - Occurs on channel k when o_k_valid & o_k_ready at the edge.
  - Read pointer advances modulo DEPTH, occupancy is decremented, and cnt_k increments (15 wraps to 0).
- Latency: a word pushed into an empty channel is visible on o_k with o_k_valid=1 in the next cycle. There is no same-cycle pass-through.
- Simultaneous push and pop, same channel, not full: both happen; occupancy unchanged; ordering preserved (FIFO).
- Channel full: i_ready=0 when a selects it, even if that channel pops in the same cycle (no full-bypass). The producer retries next cycle.
- Channel empty: o_k_ready is ignored; no pointer or count change.
- Independence:
  - Both channels may pop in the same cycle, concurrently with a push to either channel.
  - A full channel 1 does not block pushes with a=0.
- Changing a while i_valid=1 and i_ready=0 is legal; i_ready re-evaluates immediately for the new channel.
- Occupancy width: log2(DEPTH)+1 bits, range 0..DEPTH.

Test Plan:
- Reset then idle: assert rst 1 cycle -> i_ready=1, o_0_valid=o_1_valid=0, o_0=o_1=0, cnt_0=cnt_1=0.
- Routing: push 4'hA with a=0, then 4'h5 with a=1, consumers ready=0 -> o_0=A and o_1=5, both valid one cycle after each push; cnt unchanged.
- Fill/backpressure: DEPTH=2, push 3,7 on channel 0 with o_0_ready=0 -> after second push i_ready=0 for a=0 but 1 for a=1. Pop once -> o_0=7 next cycle, i_ready returns to 1, cnt_0=1.
- Concurrent push/pop: channel 1 holds one word, push 9 with a=1 and o_1_ready=1 in the same cycle -> occupancy stays 1, o_1 becomes 9, cnt_1 +1. Repeat 16 times to check cnt_1 wraps to 0.
- Reset mid-stream: both channels full, assert rst together with i_valid=1 and both ready=1 -> next cycle everything empty, counts 0, no word delivered.
- Random ordering: 200 random pushes/selects/ready patterns against a two-queue scoreboard -> per-channel order and data match exactly; no output ever changes while o_k_valid & ~o_k_ready.

Source files
------------

// File: rtl/demultiplexer_1_2_4bit_buf.sv
// Buffered 1:2 demux: one valid/ready input steered by a
// into two independent FIFOs, each with a delivered-word counter.
module demultiplexer_1_2_4bit_buf #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o_0,
  output logic             o_0_valid,
  input  logic             o_0_ready,
  output logic [WIDTH-1:0] o_1,
  output logic             o_1_valid,
  input  logic             o_1_ready,
  output logic [3:0]       cnt_0,
  output logic [3:0]       cnt_1
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [1:0]       rdy;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       full;
  logic [1:0]       empty;
  logic             acc;
  logic [WIDTH-1:0] head [2];
  logic [3:0]       cnt  [2];

  assign rdy     = {o_1_ready, o_0_ready};
  assign i_ready = ~full[a];
  assign acc     = i_valid & i_ready;
  assign push    = {a & acc, ~a & acc};

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [OW-1:0]    occ;
    logic [3:0]       c;

    assign full[k]  = (occ == FULL);
    assign empty[k] = (occ == '0);
    assign pop[k]   = ~empty[k] & rdy[k];
    assign head[k]  = empty[k] ? '0 : mem[rp];
    assign cnt[k]   = c;

    // Storage has no reset; emptiness is tracked by occ.
    always_ff @(posedge clk) begin
      if (push[k] && !rst)
        mem[wp] <= i;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        occ <= '0;
        c   <= '0;
      end else begin
        if (push[k])
          wp <= wp + 1'b1;
        if (pop[k]) begin
          rp <= rp + 1'b1;
          c  <= c + 1'b1;
        end
        if (push[k] && !pop[k])
          occ <= occ + 1'b1;
        else if (pop[k] && !push[k])
          occ <= occ - 1'b1;
      end
    end
  end

  assign o_0       = head[0];
  assign o_1       = head[1];
  assign o_0_valid = ~empty[0];
  assign o_1_valid = ~empty[1];
  assign cnt_0     = cnt[0];
  assign cnt_1     = cnt[1];

endmodule
